// File: rtl/nn_vga_pkg.sv
// Shared timing defaults, colour type and total-count helper for the VGA marker block.
package nn_vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [11:0] rgb444_t;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/nn_vga_marker_if.sv
// Raster state bundle from the timing generator to the marker/output stage.
interface nn_vga_marker_if #(
  parameter int HW = 10,
  parameter int VW = 10
);
  logic          tick;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          hsync_n;
  logic          vsync_n;
  logic          de;
  logic          sof;
  logic          eof;

  modport master (output tick, hcnt, vcnt, hsync_n, vsync_n, de, sof, eof);
  modport slave  (input  tick, hcnt, vcnt, hsync_n, vsync_n, de, sof, eof);
endinterface

// File: rtl/nn_vga_timing.sv
// Pixel divider, h/v counters and combinational sync/DE decode of the current counter position.
module nn_vga_timing
  import nn_vga_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
)(
  input  logic            clk_i,
  input  logic            rst_i,
  nn_vga_marker_if.master tim
);
  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV + 1);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          tick;
  logic          h_last, v_last;

  assign tick   = (div_q == DW'(CLK_DIV - 1));
  assign h_last = (hcnt_q == HW'(H_TOTAL - 1));
  assign v_last = (vcnt_q == VW'(V_TOTAL - 1));

  always_comb begin
    div_d  = tick ? '0 : div_q + DW'(1);
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign tim.tick    = tick;
  assign tim.hcnt    = hcnt_q;
  assign tim.vcnt    = vcnt_q;
  assign tim.hsync_n = !((hcnt_q >= HW'(H_ACTIVE + H_FP)) && (hcnt_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
  assign tim.vsync_n = !((vcnt_q >= VW'(V_ACTIVE + V_FP)) && (vcnt_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
  assign tim.de      = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
  assign tim.sof     = (hcnt_q == '0) && (vcnt_q == '0);
  assign tim.eof     = tick && h_last && v_last;

endmodule

// File: rtl/nn_vga_marker.sv
// VGA raster with a square marker at the CPU coordinate, sampled once per frame at end of frame.
// Optional NN_VGA_CROSSHAIR_EN adds full-width/height lines through the marker origin.
module nn_vga_marker
  import nn_vga_pkg::*;
#(
  parameter int      CLK_DIV    = 1,
  parameter int      H_ACTIVE   = DEF_H_ACTIVE,
  parameter int      H_FP       = DEF_H_FP,
  parameter int      H_SYNC     = DEF_H_SYNC,
  parameter int      H_BP       = DEF_H_BP,
  parameter int      V_ACTIVE   = DEF_V_ACTIVE,
  parameter int      V_FP       = DEF_V_FP,
  parameter int      V_SYNC     = DEF_V_SYNC,
  parameter int      V_BP       = DEF_V_BP,
  parameter int      MARK_SIZE  = 8,
  parameter rgb444_t MARK_COLOR = 12'hF00,
  parameter rgb444_t BG_COLOR   = 12'h000
)(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] VGA_X,
  input  logic [31:0] VGA_Y,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE,
  output logic [11:0] RGB,
  output logic        FRAME_START
);
  localparam int HW = $clog2(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VW = $clog2(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

  nn_vga_marker_if #(.HW(HW), .VW(VW)) tim_if ();

  nn_vga_timing #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i (CLK),
    .rst_i (RST),
    .tim   (tim_if)
  );

  logic [HW-1:0] cx_q;
  logic [VW-1:0] cy_q;
  logic          valid_q;
  logic          hsync_q, vsync_q, de_q, fs_q;
  rgb444_t       rgb_q;

  logic          coord_ok, in_sq, hit;
  logic [31:0]   hx, vy, cx_w, cy_w;
  rgb444_t       pix_d;

  // Full 32-bit unsigned range check; only in-range coordinates ever enable the marker.
  assign coord_ok = (VGA_X < 32'(H_ACTIVE)) && (VGA_Y < 32'(V_ACTIVE));

  always_comb begin
    hx    = 32'(tim_if.hcnt);
    vy    = 32'(tim_if.vcnt);
    cx_w  = 32'(cx_q);
    cy_w  = 32'(cy_q);
    in_sq = (hx >= cx_w) && (hx < cx_w + 32'(MARK_SIZE)) &&
            (vy >= cy_w) && (vy < cy_w + 32'(MARK_SIZE));
`ifdef NN_VGA_CROSSHAIR_EN
    hit   = valid_q && (in_sq || (tim_if.de && ((tim_if.hcnt == cx_q) || (tim_if.vcnt == cy_q))));
`else
    hit   = valid_q && in_sq;
`endif
    pix_d = BG_COLOR;
    if (!tim_if.de) pix_d = '0;
    else if (hit)   pix_d = MARK_COLOR;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      // FRAME_START updates every clock so it stays one CLK wide for any divider.
      fs_q <= tim_if.tick && tim_if.sof;
      if (tim_if.tick) begin
        hsync_q <= tim_if.hsync_n;
        vsync_q <= tim_if.vsync_n;
        de_q    <= tim_if.de;
        rgb_q   <= pix_d;
      end
      if (tim_if.eof) begin
        cx_q    <= VGA_X[HW-1:0];
        cy_q    <= VGA_Y[VW-1:0];
        valid_q <= coord_ok;
      end
    end
  end

  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign DE          = de_q;
  assign RGB         = rgb_q;
  assign FRAME_START = fs_q;

endmodule

// File: doc/nn_vga_marker.md
# nn_vga_marker

- Display-side consumer of the CPU's memory-mapped `VGA_X`/`VGA_Y` coordinate registers.
- Generates VGA raster timing (HSYNC, VSYNC, DE) and draws a solid square marker at the coordinate the CPU last wrote.
- Samples the coordinate once per frame, at the frame boundary, so the CPU can update `VGA_X`/`VGA_Y` at any time without tearing.
- Sits between the SoC core's `VGA_X`/`VGA_Y` outputs and the board's VGA DAC.

## Interface
Parameters:
- `CLK_DIV`, 1 — CLK cycles per pixel (≥1)
- `H_ACTIVE`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48 — horizontal timing in pixels
- `V_ACTIVE`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33 — vertical timing in lines
- `MARK_SIZE`, 8 — marker side length in pixels
- `MARK_COLOR`, 12'hF00 — marker RGB444
- `BG_COLOR`, 12'h000 — active-area background RGB444

Ports:
- `CLK` in 1 — single clock
- `RST` in 1 — synchronous, active-high reset
- `VGA_X` in 32 — marker column from CPU register
- `VGA_Y` in 32 — marker row from CPU register
- `HSYNC` out 1 — horizontal sync, active low
- `VSYNC` out 1 — vertical sync, active low
- `DE` out 1 — active-video flag
- `RGB` out 12 — pixel colour {R[3:0],G[3:0],B[3:0]}
- `FRAME_START` out 1 — one-CLK pulse on the tick that outputs pixel (0,0)

## Operation
- Pixel tick: divider counts 0..CLK_DIV-1; tick when divider == CLK_DIV-1. With CLK_DIV=1 every cycle is a tick.
- Counters:
  - `hcnt` runs 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP) and advances per tick.
  - `vcnt` runs 0..V_TOTAL-1 and advances when `hcnt` wraps.
  - Both wrap to 0.
- Sync:
  - HSYNC=0 iff `hcnt` ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - VSYNC=0 iff `vcnt` ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- DE=1 iff `hcnt`<H_ACTIVE and `vcnt`<V_ACTIVE.
- Coordinate capture:
  - Happens on the tick where `hcnt`==H_TOTAL-1 and `vcnt`==V_TOTAL-1.
  - Latches `cx`, `cy` and `valid`.
  - `valid` = (VGA_X < H_ACTIVE) and (VGA_Y < V_ACTIVE); the comparison uses the full 32 bits, unsigned.
  - If VGA_X/VGA_Y change during the capture cycle, the value present on that CLK edge is taken.
- Marker hit:
  - Hit = valid, `hcnt`−`cx` ∈ [0, MARK_SIZE), and `vcnt`−`cy` ∈ [0, MARK_SIZE).
  - The marker is clipped at the right and bottom edges; there is no wrap-around.
- RGB = 0 when DE=0; MARK_COLOR on a hit; otherwise BG_COLOR.

## Timing
- All outputs are registered and update only on tick edges.
- Each output reflects the counter state that was current before that edge; HSYNC, VSYNC, DE and RGB are mutually aligned.
- Latency: pixel (h,v) appears one CLK after the counters reach (h,v) with tick asserted.
- FRAME_START is high for exactly one CLK, coincident with the output of pixel (0,0).
- A new coordinate is first visible in the frame that starts immediately after its capture tick.
- Reset values:
  - HSYNC=1, VSYNC=1, DE=0, RGB=0, FRAME_START=0.
  - Internal state: `hcnt`=`vcnt`=divider=0, `cx`=`cy`=0, `valid`=0.
- The marker stays hidden until the first capture completes.
- Reset asserted mid-frame aborts the frame immediately. The first frame after reset has no marker.

## Configuration
- `NN_VGA_CROSSHAIR_EN` defined:
  - A hit also occurs when valid and (`hcnt`==`cx` or `vcnt`==`cy`) inside the active area.
  - This draws full-width and full-height lines in MARK_COLOR through the marker origin.
- `NN_VGA_CROSSHAIR_EN` undefined: square marker only.

## Structure
- Package `nn_vga_pkg`:
  - Default timing constants (640x480@60 values).
  - RGB444 colour typedef.
  - Helper function for the H_TOTAL/V_TOTAL computation.
- Sub-module `nn_vga_timing`:
  - Contains the divider, `hcnt`/`vcnt`, sync/DE decode and the end-of-frame strobe.
  - The top level adds capture, hit logic and output registers.

## Test plan
All scenarios use small timing for simulation unless stated: H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=6, V_FP=1, V_SYNC=1, V_BP=1, MARK_SIZE=2, CLK_DIV=1.
- Reset, then run 2 frames → HSYNC low exactly 2 pixels per 12-pixel line. VSYNC low exactly 1 line per 9-line frame. FRAME_START period is 108 CLK. DE high for 48 pixels per frame.
- VGA_X=3, VGA_Y=2 held from reset → frame 1 shows no marker. Frame 2 shows MARK_COLOR at pixels (3..4, 2..3), 4 pixels total; every other active pixel is BG_COLOR.
- VGA_X=7, VGA_Y=5 → marker clipped to the single pixel (7,5). VGA_X=8 → valid=0, no marker. VGA_X=32'hFFFF_FFF0 → no marker.
- Change VGA_X from 3 to 5 at mid-frame line 3 → the rest of the current frame is unchanged (marker at x=3). The next frame has the marker at x=5.
- CLK_DIV=3 → every output holds for 3 CLKs. FRAME_START is still a 1-CLK pulse, with period 324 CLK.
- `NN_VGA_CROSSHAIR_EN` defined, VGA_X=3, VGA_Y=2 → all of column 3 and row 2 is MARK_COLOR, 8+6−1=13 pixels plus the square. Reset asserted mid-frame → outputs return to reset values on the next CLK.
